// File: rtl/imem_stepper.sv
// ---------------------------------------------------------------------------
// imem_stepper
//
// Single-clock instruction-memory sequencer for board bring-up. Walks the
// address of an asynchronous-read instruction ROM from 0 to LAST_ADDR and
// wraps. It either free-runs at a prescaled rate or pauses and advances one
// word per press of a step button. The fetched word is captured one cycle
// after every address change and flagged valid.
//
// Optional feature macro: STEPPER_DEBOUNCE_EN
//   When defined, the synchronised step level is debounced. A change of level
//   is accepted only after DEB_CYC consecutive stable cycles. Without the
//   macro there is no debouncer and no debounce counter.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   run_i       1 = free-run, 0 = pause / single-step
//   speed_i     prescaler tap select (0 = FAST_TAP, 1 = SLOW_TAP)
//   step_i      raw step button, asynchronous to clk
//   clr_i       synchronous return to address 0
//   rom_addr_o  ROM address (registered)
//   rom_data_i  ROM read data, combinational from rom_addr_o
//   instr_o     registered instruction word
//   valid_o     instr_o holds the word at rom_addr_o
//   adv_o       one-cycle pulse: address changed on the last edge
//   wrap_o      one-cycle pulse: address wrapped LAST_ADDR -> 0
// ---------------------------------------------------------------------------
module imem_stepper #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int LAST_ADDR = 23,
    parameter int DIV_W     = 26,
    parameter int FAST_TAP  = 24,
    parameter int SLOW_TAP  = 25,
    parameter int DEB_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              speed_i,
    input  logic              step_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              valid_o,
    output logic              adv_o,
    output logic              wrap_o
);

    typedef enum logic [0:0] {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
    localparam logic [DIV_W-1:0]  DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    // Tick pattern: bits [TAP:0] of the prescaler equal 0 followed by all
    // ones. Built one bit wider so TAP = DIV_W-1 is still representable.
    localparam logic [DIV_W:0] FAST_SPAN = {{DIV_W{1'b0}}, 1'b1} << (FAST_TAP + 1);
    localparam logic [DIV_W:0] SLOW_SPAN = {{DIV_W{1'b0}}, 1'b1} << (SLOW_TAP + 1);
    localparam logic [DIV_W:0] FAST_M_W  = FAST_SPAN - {{DIV_W{1'b0}}, 1'b1};
    localparam logic [DIV_W:0] SLOW_M_W  = SLOW_SPAN - {{DIV_W{1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] FAST_MASK = FAST_M_W[DIV_W-1:0];
    localparam logic [DIV_W-1:0] SLOW_MASK = SLOW_M_W[DIV_W-1:0];
    localparam logic [DIV_W-1:0] FAST_VAL  = FAST_MASK >> 1;
    localparam logic [DIV_W-1:0] SLOW_VAL  = SLOW_MASK >> 1;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DIV_W-1:0]    div_cnt_r;
    logic                tick_s;
    logic [1:0]          sync_r;
    logic                step_lvl_s;
    logic                step_prev_r;
    logic                step_p_s;
    logic                advance_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic                wrap_nxt_s;
    logic                addr_chg_s;
    logic                adv_nxt_s;
    logic                load_req_s;
    logic                load_pend_r;

    // Free-running prescaler; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    // Tick decode. Each tap's pattern occurs once per its own period, so
    // switching taps can only pick up a genuine pattern match.
    always_comb begin
        tick_s = 1'b0;
        if (speed_i) begin
            tick_s = ((div_cnt_r & SLOW_MASK) == SLOW_VAL);
        end else begin
            tick_s = ((div_cnt_r & FAST_MASK) == FAST_VAL);
        end
    end

    // Two-flop synchroniser for the asynchronous step button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], step_i};
        end
    end

`ifdef STEPPER_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_lvl_r;

    // Debouncer: counts consecutive cycles the synchronised level differs
    // from the accepted level; the new level is taken on the DEB_CYC-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_r <= {DEB_W{1'b0}};
            deb_lvl_r <= 1'b0;
        end else if (sync_r[1] == deb_lvl_r) begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_r <= {DEB_W{1'b0}};
            deb_lvl_r <= sync_r[1];
        end else begin
            deb_cnt_r <= deb_cnt_r + DEB_ONE;
        end
    end

    assign step_lvl_s = deb_lvl_r;
`else
    assign step_lvl_s = sync_r[1];
`endif

    // Previous step level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_prev_r <= 1'b0;
        end else begin
            step_prev_r <= step_lvl_s;
        end
    end

    assign step_p_s = step_lvl_s & ~step_prev_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_PAUSE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and advance qualifier; advance uses the current state,
    // so a tick while paused or a step while running is simply dropped.
    always_comb begin
        state_nxt_s = state_r;
        advance_s   = 1'b0;
        case (state_r)
            ST_PAUSE: begin
                if (run_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
                advance_s = step_p_s;
            end
            ST_RUN: begin
                if (run_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
                advance_s = tick_s;
            end
            default: begin
                state_nxt_s = ST_PAUSE;
                advance_s   = 1'b0;
            end
        endcase
    end

    // Next address: clear beats advance, and a clear never reports a wrap.
    always_comb begin
        addr_nxt_s = rom_addr_o;
        wrap_nxt_s = 1'b0;
        if (clr_i) begin
            addr_nxt_s = ADDR_ZERO;
        end else if (advance_s) begin
            if (rom_addr_o == ADDR_LAST) begin
                addr_nxt_s = ADDR_ZERO;
                wrap_nxt_s = 1'b1;
            end else begin
                addr_nxt_s = rom_addr_o + ADDR_ONE;
            end
        end else begin
            addr_nxt_s = rom_addr_o;
        end
    end

    assign addr_chg_s = (addr_nxt_s != rom_addr_o);
    // A clear only pulses adv_o when it actually moved the address.
    assign adv_nxt_s  = clr_i ? addr_chg_s : advance_s;
    assign load_req_s = clr_i | advance_s;

    // Address, status pulses and instruction capture. A new load request
    // takes precedence over a pending one, so the capture always follows
    // the latest address and valid_o stays low until it lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_o  <= ADDR_ZERO;
            adv_o       <= 1'b0;
            wrap_o      <= 1'b0;
            instr_o     <= {DATA_W{1'b0}};
            valid_o     <= 1'b0;
            load_pend_r <= 1'b1;
        end else begin
            rom_addr_o <= addr_nxt_s;
            adv_o      <= adv_nxt_s;
            wrap_o     <= wrap_nxt_s;
            if (load_req_s) begin
                load_pend_r <= 1'b1;
                valid_o     <= addr_chg_s ? 1'b0 : valid_o;
            end else if (load_pend_r) begin
                instr_o     <= rom_data_i;
                valid_o     <= 1'b1;
                load_pend_r <= 1'b0;
            end else begin
                load_pend_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_stepper.sv
// ---------------------------------------------------------------------------
// tb_imem_stepper
//
// Directed bench for imem_stepper with DIV_W=8, FAST_TAP=2, SLOW_TAP=3,
// LAST_ADDR=5 and a ROM returning 0xA000_0000 + addr. Edge number e counts
// rising clock edges after reset release; outputs are sampled 1 time unit
// after each edge. The prescaler holds e after edge e, so a fast tick
// advances on edges e = 8k+4 and a slow tick on edges e = 16k+8.
// ---------------------------------------------------------------------------
module tb_imem_stepper;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int LAST_ADDR = 5;
    localparam int DIV_W     = 8;
    localparam int FAST_TAP  = 2;
    localparam int SLOW_TAP  = 3;
    localparam int DEB_CYC   = 4;

`ifdef STEPPER_DEBOUNCE_EN
    localparam int LAT   = 3 + DEB_CYC;
    localparam int PRESS = 10;
`else
    localparam int LAT   = 3;
    localparam int PRESS = 4;
`endif
    localparam int S1 = 124;
    localparam int S2 = S1 + PRESS + 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run_i = 1'b1;
    logic              speed_i = 1'b0;
    logic              step_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic [DATA_W-1:0] instr_o;
    logic              valid_o;
    logic              adv_o;
    logic              wrap_o;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;

    always #5 clk = ~clk;

    assign rom_data_i = 32'hA000_0000 + {{(DATA_W-ADDR_W){1'b0}}, rom_addr_o};

    imem_stepper #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST_ADDR),
        .DIV_W(DIV_W), .FAST_TAP(FAST_TAP), .SLOW_TAP(SLOW_TAP),
        .DEB_CYC(DEB_CYC)
    ) dut (
        .clk(clk), .rst(rst), .run_i(run_i), .speed_i(speed_i),
        .step_i(step_i), .clr_i(clr_i), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i), .instr_o(instr_o), .valid_o(valid_o),
        .adv_o(adv_o), .wrap_o(wrap_o)
    );

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
        e++;
    endtask

    // Advance to edge 'target', checking adv_o against edges a1/a2 and
    // wrap_o against edge w at every edge passed.
    task automatic run_to(input int target, input int a1, input int a2, input int w);
        while (e < target) begin
            step_edge();
            chk_b($sformatf("adv@%0d", e), adv_o, (e == a1) || (e == a2));
            chk_b($sformatf("wrap@%0d", e), wrap_o, e == w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_w("rst_addr", 32'(rom_addr_o), 32'h0);
        chk_w("rst_instr", instr_o, 32'h0);
        chk_b("rst_valid", valid_o, 1'b0);
        chk_b("rst_adv", adv_o, 1'b0);
        chk_b("rst_wrap", wrap_o, 1'b0);
        rst = 1'b0;
        e   = 0;

        // First instruction at the first edge after release
        run_to(1, -1, -1, -1);
        chk_w("first_instr", instr_o, 32'hA000_0000);
        chk_b("first_valid", valid_o, 1'b1);
        chk_w("first_addr", 32'(rom_addr_o), 32'h0);

        // Free-run, fast tap: advances every 8 cycles
        run_to(4, 4, -1, -1);
        chk_w("addr@4", 32'(rom_addr_o), 32'h1);
        chk_b("valid@4", valid_o, 1'b0);
        run_to(5, -1, -1, -1);
        chk_w("instr@5", instr_o, 32'hA000_0001);
        chk_b("valid@5", valid_o, 1'b1);
        run_to(12, 12, -1, -1);
        chk_w("addr@12", 32'(rom_addr_o), 32'h2);
        run_to(20, 20, -1, -1);
        chk_w("addr@20", 32'(rom_addr_o), 32'h3);
        run_to(28, 28, -1, -1);
        chk_w("addr@28", 32'(rom_addr_o), 32'h4);
        run_to(36, 36, -1, -1);
        chk_w("addr@36", 32'(rom_addr_o), 32'h5);
        run_to(44, 44, -1, 44);
        chk_w("addr@44", 32'(rom_addr_o), 32'h0);
        run_to(45, -1, -1, -1);
        chk_w("instr@45", instr_o, 32'hA000_0000);
        chk_b("valid@45", valid_o, 1'b1);
        run_to(52, 52, -1, -1);
        chk_w("addr@52", 32'(rom_addr_o), 32'h1);

        // Switch to slow tap: advances on 16k+8 only, nothing on the switch
        speed_i = 1'b1;
        run_to(56, 56, -1, -1);
        chk_w("addr@56", 32'(rom_addr_o), 32'h2);
        run_to(72, 72, -1, -1);
        chk_w("addr@72", 32'(rom_addr_o), 32'h3);
        run_to(104, 88, 104, -1);
        chk_w("addr@104", 32'(rom_addr_o), 32'h5);
        run_to(119, -1, -1, -1);

        // Clear coinciding with a tick at the last address
        clr_i = 1'b1;
        step_edge();
        chk_w("clr_addr", 32'(rom_addr_o), 32'h0);
        chk_b("clr_adv", adv_o, 1'b1);
        chk_b("clr_wrap", wrap_o, 1'b0);
        chk_b("clr_valid", valid_o, 1'b0);
        clr_i = 1'b0;
        run_to(121, -1, -1, -1);
        chk_w("clr_instr", instr_o, 32'hA000_0000);
        chk_b("clr_valid2", valid_o, 1'b1);

        // Pause and single-step; ticks while paused are ignored
        run_i = 1'b0;
        run_to(S1, -1, -1, -1);
        step_i = 1'b1;
        run_to(S1 + LAT, S1 + LAT, -1, -1);
        chk_w("step1_addr", 32'(rom_addr_o), 32'h1);
        chk_b("step1_valid", valid_o, 1'b0);
        run_to(S1 + LAT + 1, -1, -1, -1);
        chk_w("step1_instr", instr_o, 32'hA000_0001);
        run_to(S1 + PRESS, -1, -1, -1);
        step_i = 1'b0;
        run_to(S2, -1, -1, -1);
        step_i = 1'b1;
        run_to(S2 + LAT, S2 + LAT, -1, -1);
        chk_w("step2_addr", 32'(rom_addr_o), 32'h2);
        run_to(S2 + LAT + 1, -1, -1, -1);
        chk_w("step2_instr", instr_o, 32'hA000_0002);
        chk_b("step2_valid", valid_o, 1'b1);
        run_to(S2 + PRESS, -1, -1, -1);
        step_i = 1'b0;
`ifdef STEPPER_DEBOUNCE_EN
        // Two-cycle glitch must be rejected
        run_to(166, -1, -1, -1);
        step_i = 1'b1;
        run_to(168, -1, -1, -1);
        step_i = 1'b0;
`endif
        run_to(184, -1, -1, -1);
        chk_w("pause_addr", 32'(rom_addr_o), 32'h2);

        // Resume, then reset while the new word is still loading
        run_i = 1'b1;
        run_to(200, 200, -1, -1);
        chk_w("pre_rst_addr", 32'(rom_addr_o), 32'h3);
        chk_b("pre_rst_valid", valid_o, 1'b0);
        rst = 1'b1;
        #1;
        chk_w("mid_rst_addr", 32'(rom_addr_o), 32'h0);
        chk_w("mid_rst_instr", instr_o, 32'h0);
        chk_b("mid_rst_valid", valid_o, 1'b0);
        chk_b("mid_rst_adv", adv_o, 1'b0);
        chk_b("mid_rst_wrap", wrap_o, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e   = 0;
        run_to(1, -1, -1, -1);
        chk_w("rel_instr", instr_o, 32'hA000_0000);
        chk_b("rel_valid", valid_o, 1'b1);
        chk_w("rel_addr", 32'(rom_addr_o), 32'h0);
        run_to(8, 8, -1, -1);
        chk_w("rel_adv_addr", 32'(rom_addr_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_stepper.md
# imem_stepper

Parametrised instruction-memory stepper for the board bring-up path. It replaces the fixed divided-clock ROM address counter with a single-clock-domain sequencer. Features: selectable prescaler rate, free-run and paused/single-step modes, synchronous clear, programmable last address, and a registered instruction word with valid flag. It sits between the asynchronous-read instruction ROM and the 7-segment display mux.

## Interface
- ADDR_W, 6, ROM address width
- DATA_W, 32, ROM word width
- LAST_ADDR, 23, final address before wrap to 0; must be < 2^ADDR_W
- DIV_W, 26, prescaler counter width
- FAST_TAP, 24, prescaler bit used when speed_i=0; < DIV_W
- SLOW_TAP, 25, prescaler bit used when speed_i=1; < DIV_W
- DEB_CYC, 16, debounce stability count in clk cycles (only with STEPPER_DEBOUNCE_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run_i  in  1  1 = free-run, 0 = pause/single-step
- speed_i  in  1  prescaler tap select
- step_i  in  1  raw step button, asynchronous
- clr_i  in  1  synchronous return to address 0
- rom_addr_o  out  ADDR_W  ROM address
- rom_data_i  in  DATA_W  ROM read data, combinational from rom_addr_o
- instr_o  out  DATA_W  registered instruction word
- valid_o  out  1  instr_o matches rom_addr_o
- adv_o  out  1  one-cycle pulse: address changed this cycle
- wrap_o  out  1  one-cycle pulse: address wrapped LAST_ADDR -> 0

## Operation
- Prescaler div_cnt, DIV_W bits, free-running, +1 every cycle, wraps naturally.
- tick is combinational: div_cnt[TAP:0] == {1'b0, all ones}, with TAP selected by speed_i. Period is 2^(TAP+1) cycles. Changing speed_i never produces a spurious tick.
- step_i path: 2-flop synchroniser, then rising-edge detect giving step_p, a one-cycle pulse.
- FSM states:
  - PAUSE: reset state.
  - RUN.
  - Transitions: PAUSE -> RUN when run_i=1; RUN -> PAUSE when run_i=0. Evaluated every cycle.
- Advance condition, using the current registered state: (RUN & tick) | (PAUSE & step_p). step_p in RUN and tick in PAUSE are ignored.
- Priority: clr_i > advance.
- Advance: rom_addr_o <= (rom_addr_o == LAST_ADDR) ? 0 : rom_addr_o+1. adv_o=1 on the same edge. wrap_o=1 if the wrap branch was taken.
- clr_i: rom_addr_o <= 0 and load requested. adv_o=1 only if the address actually changed. wrap_o=0.
- Load: every address change, and the first cycle after reset release, sets load_pend. In the following cycle instr_o <= rom_data_i, valid_o <= 1, load_pend <= 0.
- valid_o drops to 0 on any edge that changes rom_addr_o.

## Timing
- Reset values: rom_addr_o=0, instr_o=0, valid_o=0, adv_o=0, wrap_o=0, div_cnt=0, state=PAUSE, load_pend=1, synchroniser flops=0.
- Load latency: address update at edge N; adv_o high and valid_o low during cycle N..N+1; instr_o and valid_o=1 at edge N+1.
- First instruction: instr_o = word 0 with valid_o=1 at the first edge after rst deasserts.
- Step latency: step_i rises -> address advances 3 edges later (2 sync + edge-detect register), without debounce.
- Advance and clr_i in the same cycle: clr_i wins; no wrap_o.
- Advance while load_pend=1: allowed. The load retargets the new address, and valid_o stays 0 until the load completes.
- rst asserted mid-operation: all state returns to reset values immediately and asynchronously.

## Configuration
- STEPPER_DEBOUNCE_EN defined:
  - The synchronised step level passes through a debouncer that accepts a level change only after DEB_CYC consecutive stable cycles.
  - The edge detect runs on the debounced level.
  - Step latency becomes 3 + DEB_CYC edges.
  - Glitches shorter than DEB_CYC cycles cause no advance.
- STEPPER_DEBOUNCE_EN undefined: no debouncer and no debounce counter logic; every synchronised rising edge advances.

## Test plan
- Use DIV_W=8, FAST_TAP=2, SLOW_TAP=3, LAST_ADDR=5, and a ROM model with word = 0xA000_0000 + addr.
- Reset release with run_i=1, speed_i=0:
  - instr_o=0xA000_0000, valid_o=1 at the first edge.
  - Address advances every 8 cycles: 1,2,...,5,0.
  - wrap_o pulses exactly once, on the 5->0 advance.
- speed_i toggled mid-run: advance period becomes 16 cycles; no extra advance on the toggle cycle.
- run_i=0, step_i pulsed high for 4 cycles, twice:
  - Address goes 0->1->2, each change 3 edges after the rising edge.
  - instr_o=0xA000_0002, valid_o=1 one cycle after the second change.
- clr_i asserted on the same cycle as a tick at address 5: address=0, adv_o=1, wrap_o=0.
- With STEPPER_DEBOUNCE_EN and DEB_CYC=4: a 2-cycle step glitch gives no advance; a 10-cycle press gives one advance at 7 edges.
- rst pulsed while valid_o=0 at address 3: all outputs return to 0 immediately; after release, address 0 is loaded normally.
